// File: rtl/midi_voice_allocator.sv
// MIDI channel-message parser with running status, driving a polyphonic voice table.
// A full table is handled by round-robin stealing.
module midi_voice_allocator #(
    parameter int         NUM_VOICES = 4,
    parameter logic [3:0] CHANNEL    = 4'd0,
    parameter bit         OMNI       = 1'b0,
    localparam int        VW         = $clog2(NUM_VOICES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vel,
    output logic                    evt_valid,
    output logic                    evt_on,
    output logic [VW-1:0]           evt_voice,
    output logic                    evt_steal,
    output logic [7:0]              steal_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } parse_state_t;

    parse_state_t state, state_next;
    logic [7:0]   status, status_next;
    logic [6:0]   d1, d1_next;
    logic         msg_done;
    logic         len_one;

    logic          chan_ok, note_on, note_off;
    logic          hit, free;
    logic [VW-1:0] hit_idx, free_idx;
    logic [VW-1:0] steal_ptr;

    assign len_one = (status[7:4] == 4'hC) || (status[7:4] == 4'hD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            status <= 8'h00;
            d1     <= 7'h00;
        end else begin
            state  <= state_next;
            status <= status_next;
            d1     <= d1_next;
        end
    end

    // Realtime bytes fall through untouched so they can sit between data bytes.
    always_comb begin
        state_next  = state;
        status_next = status;
        d1_next     = d1;
        msg_done    = 1'b0;
        if (rx_valid) begin
            if (rx_data >= 8'hF8) begin
                state_next = state;
            end else if (rx_data >= 8'hF0) begin
                status_next = 8'h00;
                state_next  = IDLE;
            end else if (rx_data[7]) begin
                status_next = rx_data;
                state_next  = WAIT_D1;
            end else begin
                case (state)
                    WAIT_D1: begin
                        d1_next = rx_data[6:0];
                        if (len_one) msg_done = 1'b1;
                        else         state_next = WAIT_D2;
                    end
                    WAIT_D2: begin
                        msg_done   = 1'b1;
                        state_next = WAIT_D1;
                    end
                    default: state_next = state;
                endcase
            end
        end
    end

    // On a note completion rx_data holds the velocity and d1 the key.
    assign chan_ok  = OMNI || (status[3:0] == CHANNEL);
    assign note_on  = msg_done && chan_ok && (state == WAIT_D2) &&
                      (status[7:4] == 4'h9) && (rx_data[6:0] != 7'd0);
    assign note_off = msg_done && chan_ok && (state == WAIT_D2) &&
                      ((status[7:4] == 4'h8) ||
                       ((status[7:4] == 4'h9) && (rx_data[6:0] == 7'd0)));

    // Scanning from the top down leaves the lowest matching index.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_active[i] && (voice_note[7*i +: 7] == d1)) begin
                hit     = 1'b1;
                hit_idx = VW'(i);
            end
            if (!voice_active[i]) begin
                free     = 1'b1;
                free_idx = VW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voice_active <= '0;
            voice_note   <= '0;
            voice_vel    <= '0;
            evt_valid    <= 1'b0;
            evt_on       <= 1'b0;
            evt_voice    <= '0;
            evt_steal    <= 1'b0;
            steal_cnt    <= 8'h00;
            steal_ptr    <= '0;
        end else begin
            evt_valid <= 1'b0;
            if (note_on) begin
                evt_valid <= 1'b1;
                evt_on    <= 1'b1;
                if (hit) begin
                    voice_vel[7*hit_idx +: 7] <= rx_data[6:0];
                    evt_voice                 <= hit_idx;
                    evt_steal                 <= 1'b0;
                end else if (free) begin
                    voice_note[7*free_idx +: 7] <= d1;
                    voice_vel[7*free_idx +: 7]  <= rx_data[6:0];
                    voice_active[free_idx]      <= 1'b1;
                    evt_voice                   <= free_idx;
                    evt_steal                   <= 1'b0;
                end else begin
                    voice_note[7*steal_ptr +: 7] <= d1;
                    voice_vel[7*steal_ptr +: 7]  <= rx_data[6:0];
                    evt_voice                    <= steal_ptr;
                    evt_steal                    <= 1'b1;
                    if (steal_cnt != 8'hFF) steal_cnt <= steal_cnt + 8'd1;
                    if (steal_ptr == VW'(NUM_VOICES - 1)) steal_ptr <= '0;
                    else                                  steal_ptr <= steal_ptr + 1'b1;
                end
            end else if (note_off && hit) begin
                voice_active[hit_idx] <= 1'b0;
                evt_valid             <= 1'b1;
                evt_on                <= 1'b0;
                evt_voice             <= hit_idx;
                evt_steal             <= 1'b0;
            end
        end
    end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Sequences the MIDI receive datapath: consumes the byte stream from the serial receiver and parses channel messages, including running status.
- Turns note-on/note-off into a polyphonic voice table of NUM_VOICES slots, stealing a slot when all are busy.
- Voice table drives the LED/tone stage downstream, replacing the single-note hold register.

Parameters:
- NUM_VOICES, 4, voice slots (2..8); index width VW = clog2(NUM_VOICES).
- CHANNEL, 0, 4-bit MIDI channel accepted.
- OMNI, 0, 1 = accept note messages on all channels.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- voice_active  out  NUM_VOICES  bit i = slot i sounding
- voice_note  out  7*NUM_VOICES  key of slot i at [7i+6:7i]
- voice_vel  out  7*NUM_VOICES  velocity of slot i
- evt_valid  out  1  one-cycle pulse: voice table changed
- evt_on  out  1  1 = allocate/retrigger, 0 = release (qualified by evt_valid)
- evt_voice  out  VW  slot affected by the event
- evt_steal  out  1  event overwrote an active slot
- steal_cnt  out  8  saturating count of steals

Behaviour:
- Reset: every output is 0. Running status cleared. Parser in IDLE. steal_ptr = 0.
- Bytes are processed only on cycles with rx_valid=1. Other cycles hold all state.
- Byte classes:
  - 0xF8-0xFF (realtime): ignored completely. No state change, running status kept.
  - 0xF0-0xF7: running status cleared, parser to IDLE.
  - 0x80-0xEF (status): sets running status and length. Length is 2 for 8n/9n/An/Bn/En, 1 for Cn/Dn. Parser to WAIT_D1.
  - 0x00-0x7F (data): handled by the parser state below.
- Parser states:
  - IDLE: data bytes ignored.
  - WAIT_D1: store d1. If length is 1, the message is complete; stay in WAIT_D1 (running status). Otherwise go to WAIT_D2.
  - WAIT_D2: store d2. Message complete; return to WAIT_D1.
- Only 8n/9n with n==CHANNEL (or OMNI=1) act on the voice table. All other messages are parsed for byte alignment only.
- Action fires on the clk edge that samples the completing byte. Table outputs and evt_* are registered and visible the following cycle, i.e. one cycle latency. evt_* is valid for exactly one cycle.
- Note-on (9n, vel>0), priority order:
  1. If key already active in slot k: update vel[k]; evt_on=1, evt_voice=k, evt_steal=0.
  2. Else pick the lowest-index inactive slot: note/vel written, active set.
  3. Else (table full): overwrite slot steal_ptr; evt_steal=1; steal_cnt+1, saturating at 255; steal_ptr = (steal_ptr+1) mod NUM_VOICES.
- Note-off (8n, any vel; or 9n with vel=0):
  - If key active in slot k: active[k] cleared; note/vel fields keep their last values; evt_on=0, evt_voice=k.
  - If key is not active: no event, nothing changes.
- Invariant: a key never occupies more than one slot.
- A new status byte arriving mid-message abandons the partial message with no action.
- A realtime byte arriving between d1 and d2 does not break the message.
- Reset asserted mid-message: the partial message is discarded and the table is cleared on that edge.
- steal_ptr is not changed by releases.

Test Plan:
- 0x90,0x3C,0x64 -> next cycle voice_active=0001, note0=0x3C, vel0=0x64; evt_valid pulse, evt_on=1, evt_voice=0.
- Running status: 0x90,0x3C,0x64,0x40,0x50,0x3C,0x00 -> slot0 (0x3C) and slot1 (0x40) allocated, then slot0 released. voice_active=0010; exactly 3 evt pulses.
- Fill and steal (NUM_VOICES=4): note-ons for keys 60,61,62,63,64 -> 64 lands in slot0 with evt_steal=1, steal_cnt=1, steal_ptr=1. A further note-on for 65 lands in slot1.
- Filtering (CHANNEL=0): 0x91,0x3C,0x64 -> no event. 0xC0,0x05 followed by data 0x3C -> treated as program change, no note activity. 0x80 for an inactive key -> no event.
- 0x90,0x3C,0xF8,0x64 -> note allocated normally. 0x90,0x3C,0xB0,0x07,0x7F -> no note event.
- Assert rst after 0x90,0x3C -> all outputs 0. A subsequent 0x64 is ignored (IDLE).
